serial_adder_host: RTL

Host-side counterpart of the serial adder interface. It accepts parallel operand pairs over a valid/ready handshake and shifts them MSB-first onto the adder's serial inputs (`en_i`/`ina`/`inb`). It then collects the adder's serial result (`en_o`/`out`) and returns it as a parallel sum over a second valid/ready handshake. It sits between a transaction source (bench driver or bus-side logic) and the serial adder.

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_shift_reg.sv | 25 ++
 rtl/serial_adder_host.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types/constants for the serial adder host: FSM states, default width, adder latency.
// Latency: n/a (declarations only). Backpressure: n/a.
package serial_adder_pkg;

    localparam int OP_W_DEF  = 2;
    localparam int ADDER_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_HOLD = 3'd4
    } host_state_e;

endpackage

// File: rtl/serial_shift_reg.sv
// Shift register with parallel load, MSB-side serial out and LSB-side serial in.
// Latency: one cycle per load/shift. Backpressure: none, load wins over shift.
module serial_shift_reg #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= (q << 1) | W'(sin);
        end
    end

endmodule

// File: rtl/serial_adder_host.sv
// Serialises operand pairs MSB-first to the serial adder and reassembles its OP_W+1 bit result.
// Latency: accept to out_valid OP_W+5 cycles. Backpressure: in_ready only in IDLE, result held until out_ready.
// Optional WAIT timeout via SERIAL_ADDER_HOST_TIMEOUT_EN.
module serial_adder_host
    import serial_adder_pkg::*;
#(
    parameter int OP_W    = OP_W_DEF,
    parameter int TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [OP_W-1:0] in_a,
    input  logic [OP_W-1:0] in_b,
    output logic          ser_en,
    output logic          ser_a,
    output logic          ser_b,
    input  logic          res_en,
    input  logic          res_bit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OP_W:0] out_sum,
    output logic          err
);

    localparam int CW = $clog2(OP_W + 1);

    host_state_e     state;
    logic [CW-1:0]   cnt;
    logic [OP_W-1:0] a_q;
    logic [OP_W-1:0] b_q;
    logic [OP_W:0]   sum_q;
    logic            accept;
    logic            op_shift;
    logic            res_load;
    logic            res_shift;
    logic [OP_W:0]   res_val;

`ifdef SERIAL_ADDER_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;
`endif

    always_comb begin
        accept    = in_valid && in_ready;
        op_shift  = (state == ST_SEND);
        // WAIT capture seeds the result with its MSB; a RECV dropout clears the partial result.
        res_load  = ((state == ST_WAIT) && res_en) || ((state == ST_RECV) && !res_en);
        res_val   = (state == ST_WAIT) ? {{OP_W{1'b0}}, res_bit} : '0;
        res_shift = (state == ST_RECV) && res_en;
    end

    serial_shift_reg #(.W(OP_W)) u_sr_a (
        .clk(clk), .rst_n(rst_n), .load(accept), .load_val(in_a),
        .shift(op_shift), .sin(1'b0), .q(a_q)
    );

    serial_shift_reg #(.W(OP_W)) u_sr_b (
        .clk(clk), .rst_n(rst_n), .load(accept), .load_val(in_b),
        .shift(op_shift), .sin(1'b0), .q(b_q)
    );

    serial_shift_reg #(.W(OP_W + 1)) u_sr_res (
        .clk(clk), .rst_n(rst_n), .load(res_load), .load_val(res_val),
        .shift(res_shift), .sin(res_bit), .q(sum_q)
    );

    // Operand registers shift in zeros, so their MSBs are already 0 outside SEND.
    assign ser_a   = a_q[OP_W-1];
    assign ser_b   = b_q[OP_W-1];
    assign out_sum = sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            ser_en    <= 1'b0;
            out_valid <= 1'b0;
            err       <= 1'b0;
`ifdef SERIAL_ADDER_HOST_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt      <= CW'(OP_W);
                        in_ready <= 1'b0;
                        ser_en   <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        ser_en <= 1'b0;
                        state  <= ST_WAIT;
`ifdef SERIAL_ADDER_HOST_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                ST_WAIT: begin
                    if (res_en) begin
                        cnt   <= CW'(OP_W);
                        state <= ST_RECV;
                    end
`ifdef SERIAL_ADDER_HOST_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_RECV: begin
                    if (!res_en) begin
                        err      <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            out_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
